// File: rtl/fb_write_scheduler_if.sv
// Framebuffer write-scheduler bus: pixel updates and clear requests in, registered RAM write port out.
// The optional drop_count signal exists only when FB_DROP_COUNT_EN is defined.
interface fb_write_scheduler_if #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned COLOR_W = 8
);
    logic               pix_valid;
    logic [7:0]         pix_x;
    logic [7:0]         pix_y;
    logic [COLOR_W-1:0] pix_color;
    logic               clear_req;
    logic [COLOR_W-1:0] clear_color;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [COLOR_W-1:0] wr_data;
    logic               busy;
    logic               fifo_full;
`ifdef FB_DROP_COUNT_EN
    logic [15:0]        drop_count;
`endif

    modport master (
`ifdef FB_DROP_COUNT_EN
        input  drop_count,
`endif
        output pix_valid, pix_x, pix_y, pix_color, clear_req, clear_color,
        input  wr_en, wr_addr, wr_data, busy, fifo_full
    );

    modport slave (
`ifdef FB_DROP_COUNT_EN
        output drop_count,
`endif
        input  pix_valid, pix_x, pix_y, pix_color, clear_req, clear_color,
        output wr_en, wr_addr, wr_data, busy, fifo_full
    );
endinterface

// File: rtl/fb_write_scheduler.sv
// Owns the framebuffer write port: queues range-checked pixel writes and runs full-screen clears.
// Optional feature macro: FB_DROP_COUNT_EN (adds a saturating dropped-pixel counter).
module fb_write_scheduler #(
    parameter int unsigned FB_W       = 240,
    parameter int unsigned FB_H       = 240,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned COLOR_W    = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                clock,
    input logic                reset_n,
    fb_write_scheduler_if.slave bus
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENT_W = ADDR_W + COLOR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t             state_q, state_d;
    logic [ENT_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count, count_d;
    logic [ADDR_W-1:0]  sweep;
    logic [COLOR_W-1:0] clear_color_q;
    logic               wr_en_q, busy_q, fifo_full_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [COLOR_W-1:0] wr_data_q;
    logic               wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_d;
    logic [COLOR_W-1:0] wr_data_d;
    logic               in_range, push, pop, clear_acc;
    logic [ADDR_W-1:0]  pix_addr;
    logic [ENT_W-1:0]   head;

    assign in_range = (32'(bus.pix_x) < FB_W) && (32'(bus.pix_y) < FB_H);
    assign push     = bus.pix_valid && in_range && (count < DEPTH_CNT);
    assign pix_addr = ADDR_W'(32'(bus.pix_x) * FB_H + 32'(bus.pix_y));
    assign head     = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state, queue pop/flush decisions and next write-port values.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        clear_acc = 1'b0;
        count_d   = count + CNT_W'(push);
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                if (bus.clear_req) begin
                    clear_acc = 1'b1;
                    state_d   = CLEAR;
                end else if (count != '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.clear_req) begin
                    clear_acc = 1'b1;
                    state_d   = CLEAR;
                end else if (count != '0) begin
                    pop       = 1'b1;
                    count_d   = count - CNT_W'(1) + CNT_W'(push);
                    wr_en_d   = 1'b1;
                    wr_addr_d = head[ENT_W-1:COLOR_W];
                    wr_data_d = head[COLOR_W-1:0];
                    if (count_d == '0) state_d = IDLE;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = sweep;
                wr_data_d = clear_color_q;
                if (sweep == LAST_ADDR) state_d = (count_d != '0) ? DRAIN : IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Accepted clear discards queued pixels; only a same-cycle push survives.
        if (clear_acc) count_d = CNT_W'(push);
    end

    always_ff @(posedge clock) begin
        if (reset_n && push) mem[wr_ptr] <= {pix_addr, bus.pix_color};
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            sweep         <= '0;
            clear_color_q <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            busy_q        <= 1'b0;
            fifo_full_q   <= 1'b0;
        end else begin
            count       <= count_d;
            fifo_full_q <= (count_d == DEPTH_CNT);
            busy_q      <= (state_d == CLEAR);
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (clear_acc)  rd_ptr <= wr_ptr;
            else if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            if (clear_acc) begin
                clear_color_q <= bus.clear_color;
                sweep         <= '0;
            end else if (state_q == CLEAR) begin
                sweep <= (sweep == LAST_ADDR) ? '0 : sweep + ADDR_W'(1);
            end
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = busy_q;
    assign bus.fifo_full = fifo_full_q;

`ifdef FB_DROP_COUNT_EN
    logic [15:0] drop_q;

    // Every rejected strobe counts (out of range or queue full); saturates.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            drop_q <= '0;
        end else if (bus.pix_valid && !push && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign bus.drop_count = drop_q;
`endif
endmodule

// File: tb/tb_fb_write_scheduler.sv
// Scoreboard bench for fb_write_scheduler: stimulus pushes expected writes, a monitor checks each write.
module tb_fb_write_scheduler;
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    fb_write_scheduler_if bus_if ();

    fb_write_scheduler dut (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Monitor: every write the DUT presents must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus_if.wr_en) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", bus_if.wr_addr, bus_if.wr_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus_if.wr_addr !== e.addr || bus_if.wr_data !== e.data) begin
                    n_fail++;
                    $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                             bus_if.wr_addr, bus_if.wr_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input logic v, input logic [7:0] x, input logic [7:0] y, input logic [7:0] c);
        bus_if.pix_valid = v;
        bus_if.pix_x     = x;
        bus_if.pix_y     = y;
        bus_if.pix_color = c;
    endtask

    task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        bus_if.clear_req   = 1'b0;
        bus_if.clear_color = 8'h00;
        set_pix(1'b1, 8'd1, 8'd1, 8'hAA);
        reset_n = 1'b0;

        // Reset held two cycles with a pixel strobe active.
        tick();
        tick();
        @(negedge clk);
        chk("rst_wr_en", 32'(bus_if.wr_en), 32'd0);
        chk("rst_wr_addr", 32'(bus_if.wr_addr), 32'd0);
        chk("rst_wr_data", 32'(bus_if.wr_data), 32'd0);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_fifo_full", 32'(bus_if.fifo_full), 32'd0);
`ifdef FB_DROP_COUNT_EN
        chk("rst_drop_count", 32'(bus_if.drop_count), 32'd0);
`endif
        reset_n = 1'b1;
        set_pix(1'b0, 8'd0, 8'd0, 8'h00);
        repeat (4) tick();

        // Single pixel (3,5): address 3*240+5 = 725, written exactly at edge t+2.
        expect_wr(16'd725, 8'hE0);
        set_pix(1'b1, 8'd3, 8'd5, 8'hE0);
        tick();
        set_pix(1'b0, 8'd0, 8'd0, 8'h00);
        @(negedge clk);
        chk("lat_t0_wr_en", 32'(bus_if.wr_en), 32'd0);
        @(negedge clk);
        chk("lat_t1_wr_en", 32'(bus_if.wr_en), 32'd0);
        @(negedge clk);
        chk("lat_t2_wr_en", 32'(bus_if.wr_en), 32'd1);
        @(negedge clk);
        chk("lat_t3_wr_en", 32'(bus_if.wr_en), 32'd0);

        // Out-of-range pixels are dropped.
        set_pix(1'b1, 8'd240, 8'd0, 8'h55);
        tick();
        set_pix(1'b1, 8'd0, 8'd240, 8'h55);
        tick();
        set_pix(1'b0, 8'd0, 8'd0, 8'h00);
        repeat (4) tick();
`ifdef FB_DROP_COUNT_EN
        @(negedge clk);
        chk("range_drop_count", 32'(bus_if.drop_count), 32'd2);
`endif

        // Two pixels queued, then clear + pixel (10,10): the two are flushed, (10,10) survives.
        set_pix(1'b1, 8'd1, 8'd2, 8'h11);
        tick();
        set_pix(1'b1, 8'd2, 8'd3, 8'h22);
        tick();
        for (int i = 0; i < 57600; i++) expect_wr(16'(i), 8'h1C);
        expect_wr(16'd2410, 8'h03);
        expect_wr(16'd4830, 8'h41);
        expect_wr(16'd5071, 8'h42);
        expect_wr(16'd5312, 8'h43);
        bus_if.clear_req   = 1'b1;
        bus_if.clear_color = 8'h1C;
        set_pix(1'b1, 8'd10, 8'd10, 8'h03);
        tick();
        bus_if.clear_req = 1'b0;
        set_pix(1'b0, 8'd0, 8'd0, 8'h00);
        @(negedge clk);
        chk("clear_busy_rise", 32'(bus_if.busy), 32'd1);

        // During the sweep: five pixels against one queued entry, plus an ignored second clear.
        bus_if.clear_req   = 1'b1;
        bus_if.clear_color = 8'hFF;
        set_pix(1'b1, 8'd20, 8'd30, 8'h41);
        tick();
        bus_if.clear_req = 1'b0;
        set_pix(1'b1, 8'd21, 8'd31, 8'h42);
        tick();
        set_pix(1'b1, 8'd22, 8'd32, 8'h43);
        tick();
        set_pix(1'b1, 8'd23, 8'd33, 8'h44);
        tick();
        set_pix(1'b1, 8'd24, 8'd34, 8'h45);
        tick();
        set_pix(1'b0, 8'd0, 8'd0, 8'h00);
        @(negedge clk);
        chk("ovf_fifo_full", 32'(bus_if.fifo_full), 32'd1);
        chk("ovf_busy", 32'(bus_if.busy), 32'd1);
`ifdef FB_DROP_COUNT_EN
        chk("ovf_drop_count", 32'(bus_if.drop_count), 32'd4);
`endif

        for (int i = 0; i < 60000; i++) begin
            @(negedge clk);
            if (!bus_if.busy) break;
        end
        chk("clear_busy_fall", 32'(bus_if.busy), 32'd0);

        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        repeat (5) tick();
        @(negedge clk);
        chk("end_wr_en", 32'(bus_if.wr_en), 32'd0);
        chk("end_busy", 32'(bus_if.busy), 32'd0);
        chk("end_fifo_full", 32'(bus_if.fifo_full), 32'd0);
`ifdef FB_DROP_COUNT_EN
        chk("end_drop_count", 32'(bus_if.drop_count), 32'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
